// File: rtl/merge_pipe_oem.sv
// Pipelined Batcher odd-even merge: two ascending N-element halves in, one ascending 2N vector out.
// Optional macro MERGE_PIPE_IDX_TAG_EN: elements carry their input slot as a tie-break tag, exposed on out_idx.
module merge_pipe_oem #(
  parameter int WIDTH = 3,
  parameter int N     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*N*WIDTH-1:0]        inba,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*N*WIDTH-1:0]        c,
`ifdef MERGE_PIPE_IDX_TAG_EN
  output logic [2*N*$clog2(2*N)-1:0]  out_idx,
`endif
  output logic                        out_ord_err,
  output logic                        busy
);
  localparam int IDXW = $clog2(2*N);
  localparam int S    = IDXW;
`ifdef MERGE_PIPE_IDX_TAG_EN
  localparam int TW   = IDXW;
`else
  localparam int TW   = 0;
`endif
  localparam int EW   = WIDTH + TW;
  localparam int VW   = 2*N*EW;

  logic                  adv;
  logic                  ord_err;
  logic [VW-1:0]         in_vec;
  logic [VW-1:0]         out_vec;
  logic [S-1:0][VW-1:0]  stage_d;
  logic [S-1:0][VW-1:0]  stage_q;
  logic [S-1:0]          vld_q;
  logic [S-1:0]          err_q;

  // An input half is out of order if any neighbour pair descends.
  always_comb begin
    ord_err = 1'b0;
    for (int k = 0; k < N-1; k++) begin
      if (inba[k*WIDTH +: WIDTH] > inba[(k+1)*WIDTH +: WIDTH])
        ord_err = 1'b1;
      if (inba[(N+k)*WIDTH +: WIDTH] > inba[(N+k+1)*WIDTH +: WIDTH])
        ord_err = 1'b1;
    end
  end

  // Tagged elements are {value, slot}, so a plain unsigned compare breaks ties by slot.
  always_comb begin
    in_vec = '0;
    for (int k = 0; k < 2*N; k++) begin
`ifdef MERGE_PIPE_IDX_TAG_EN
      in_vec[k*EW +: EW] = {inba[k*WIDTH +: WIDTH], IDXW'(k)};
`else
      in_vec[k*EW +: EW] = inba[k*WIDTH +: WIDTH];
`endif
    end
  end

  // Level l compares at distance K = N>>l; after the first level pairs start at K in blocks of 2K.
  for (genvar l = 0; l < S; l++) begin : g_lvl
    localparam int K  = N >> l;
    localparam int J0 = (l == 0) ? 0 : K;
    localparam int NB = (l == 0) ? 1 : (N / K) - 1;
    logic [VW-1:0] src;
    logic [VW-1:0] dst;

    if (l == 0) begin : g_first
      assign src = in_vec;
    end else begin : g_next
      assign src = stage_q[l-1];
    end

    always_comb begin
      dst = src;
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < K; i++) begin
          if (src[(J0 + 2*K*b + i)*EW +: EW] > src[(J0 + 2*K*b + i + K)*EW +: EW]) begin
            dst[(J0 + 2*K*b + i)*EW +: EW]     = src[(J0 + 2*K*b + i + K)*EW +: EW];
            dst[(J0 + 2*K*b + i + K)*EW +: EW] = src[(J0 + 2*K*b + i)*EW +: EW];
          end
        end
      end
    end

    assign stage_d[l] = dst;
  end

  assign adv = !out_valid || out_ready;

  // Pipeline registers: one bank per compare level, the whole chain stalls together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      vld_q   <= '0;
      err_q   <= '0;
    end else if (adv) begin
      stage_q <= stage_d;
      vld_q   <= {vld_q[S-2:0], in_valid};
      err_q   <= {err_q[S-2:0], ord_err};
    end
  end

  assign in_ready    = adv;
  assign out_valid   = vld_q[S-1];
  assign out_ord_err = err_q[S-1];
  assign busy        = |vld_q;
  assign out_vec     = stage_q[S-1];

  always_comb begin
    c = '0;
    for (int k = 0; k < 2*N; k++)
      c[k*WIDTH +: WIDTH] = out_vec[k*EW + TW +: WIDTH];
  end

`ifdef MERGE_PIPE_IDX_TAG_EN
  always_comb begin
    out_idx = '0;
    for (int k = 0; k < 2*N; k++)
      out_idx[k*IDXW +: IDXW] = out_vec[k*EW +: IDXW];
  end
`endif

endmodule

// File: tb/tb_merge_pipe_oem.sv
// Scoreboard bench for merge_pipe_oem (WIDTH=3, N=8): reference merge is a plain sort of {value, slot} keys.
module tb_merge_pipe_oem;
  localparam int WIDTH = 3;
  localparam int N     = 8;
  localparam int E     = 2*N;
  localparam int IDXW  = 4;
  localparam int S     = 4;

  typedef struct {
    logic [E*WIDTH-1:0] c;
    logic [E*IDXW-1:0]  idx;
    logic               err;
    logic               chk_c;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [E*WIDTH-1:0] inba = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [E*WIDTH-1:0] c;
  logic               out_ord_err;
  logic               busy;
`ifdef MERGE_PIPE_IDX_TAG_EN
  logic [E*IDXW-1:0]  out_idx;
`endif

  exp_t sb[$];
  exp_t dummy;
  exp_t em;
  int   checks = 0;
  int   failures = 0;

  merge_pipe_oem #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inba(inba),
    .out_valid(out_valid), .out_ready(out_ready), .c(c),
`ifdef MERGE_PIPE_IDX_TAG_EN
    .out_idx(out_idx),
`endif
    .out_ord_err(out_ord_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: stable sort by value (slot breaks ties), plus neighbour order check per half.
  function automatic exp_t model(input logic [E*WIDTH-1:0] v);
    int   q[$];
    exp_t r;
    for (int k = 0; k < E; k++) q.push_back((int'(v[k*WIDTH +: WIDTH]) << IDXW) | k);
    q.sort();
    r.c = '0;
    r.idx = '0;
    for (int k = 0; k < E; k++) begin
      r.c[k*WIDTH +: WIDTH] = WIDTH'(q[k] >> IDXW);
      r.idx[k*IDXW +: IDXW] = IDXW'(q[k] % E);
    end
    r.err = 1'b0;
    for (int k = 0; k < N-1; k++)
      if (v[k*WIDTH +: WIDTH] > v[(k+1)*WIDTH +: WIDTH] ||
          v[(N+k)*WIDTH +: WIDTH] > v[(N+k+1)*WIDTH +: WIDTH]) r.err = 1'b1;
    r.chk_c = !r.err;
    return r;
  endfunction

  function automatic logic [E*WIDTH-1:0] rand_sorted();
    int a[$];
    int b[$];
    logic [E*WIDTH-1:0] v;
    for (int k = 0; k < N; k++) begin
      a.push_back($urandom_range(0, 7));
      b.push_back($urandom_range(0, 7));
    end
    a.sort();
    b.sort();
    v = '0;
    for (int k = 0; k < N; k++) begin
      v[k*WIDTH +: WIDTH]     = WIDTH'(a[k]);
      v[(N+k)*WIDTH +: WIDTH] = WIDTH'(b[k]);
    end
    return v;
  endfunction

  function automatic logic [E*WIDTH-1:0] rand_raw();
    logic [E*WIDTH-1:0] v;
    for (int k = 0; k < E; k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 7));
    return v;
  endfunction

  task automatic drive_cycle(input logic v, input logic [E*WIDTH-1:0] d, input logic ordy,
                             input exp_t e, output logic acc);
    @(negedge clk);
    out_ready = ordy;
    in_valid  = v;
    inba      = d;
    #1;
    acc = v && in_ready;
    if (acc) sb.push_back(e);
  endtask

  task automatic send(input logic [E*WIDTH-1:0] d, input exp_t e);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      drive_cycle(1'b1, d, 1'b1, e, acc);
      n++;
    end
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      drive_cycle(1'b0, '0, 1'b1, dummy, acc);
      n++;
    end
    drive_cycle(1'b0, '0, 1'b1, dummy, acc);
    check("drain_empty", sb.size(), 0);
    check("drain_busy", busy, 1'b0);
  endtask

  // Monitor: pops on every output handshake, and checks that stalled outputs hold.
  logic               stall_prev = 1'b0;
  logic [E*WIDTH-1:0] c_prev;
  logic               err_prev;
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_c", c, c_prev);
        check("hold_err", out_ord_err, err_prev);
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got out_valid with empty scoreboard expected none");
        end else begin
          em = sb.pop_front();
          if (em.chk_c) check("c", c, em.c);
          check("ord_err", out_ord_err, em.err);
`ifdef MERGE_PIPE_IDX_TAG_EN
          if (em.chk_c) check("out_idx", out_idx, em.idx);
`endif
        end
      end
      stall_prev = out_valid && !out_ready;
      c_prev     = c;
      err_prev   = out_ord_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [E*WIDTH-1:0] d;
  logic [E*WIDTH-1:0] vecs[10];
  exp_t               e;
  logic               acc;
  logic               ordy;
  logic               holding;
  int                 idx;
  int                 cyc;
  int                 n;
  logic               got;

  initial begin
    dummy = model('0);
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_c", c, '0);
    check("rst_err", out_ord_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Interleaved halves 0..7 / 0..7.
    for (int k = 0; k < E; k++) d[k*WIDTH +: WIDTH] = WIDTH'(k % N);
    e = model(d);
    for (int k = 0; k < E; k++) e.c[k*WIDTH +: WIDTH] = WIDTH'(k / 2);
    e.err = 1'b0;
    send(d, e);
    // Disjoint halves, then swapped.
    for (int k = 0; k < E; k++) d[k*WIDTH +: WIDTH] = (k < N) ? 3'd7 : 3'd0;
    e = model(d);
    for (int k = 0; k < E; k++) e.c[k*WIDTH +: WIDTH] = (k < N) ? 3'd0 : 3'd7;
    send(d, e);
    for (int k = 0; k < E; k++) d[k*WIDTH +: WIDTH] = (k < N) ? 3'd0 : 3'd7;
    e = model(d);
    for (int k = 0; k < E; k++) e.c[k*WIDTH +: WIDTH] = (k < N) ? 3'd0 : 3'd7;
    send(d, e);
    // All equal values: slots must come out in order when tags are enabled.
    for (int k = 0; k < E; k++) d[k*WIDTH +: WIDTH] = 3'd5;
    e = model(d);
    for (int k = 0; k < E; k++) begin
      e.c[k*WIDTH +: WIDTH]  = 3'd5;
      e.idx[k*IDXW +: IDXW]  = IDXW'(k);
    end
    send(d, e);
    drain();

    // Order error flanked by sorted vectors.
    d = rand_sorted();
    send(d, model(d));
    d = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
         3'd7, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 3'd3};
    e = model(d);
    e.err   = 1'b1;
    e.chk_c = 1'b0;
    send(d, e);
    d = rand_sorted();
    send(d, model(d));
    drain();

    // Backpressure: in_valid held high, out_ready low for cycles 5..10.
    for (int t = 0; t < 10; t++) vecs[t] = rand_sorted();
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 200) begin
      ordy = !(cyc >= 5 && cyc <= 10);
      drive_cycle(1'b1, vecs[idx], ordy, model(vecs[idx]), acc);
      if (acc) idx++;
      cyc++;
    end
    check("bp_all_sent", idx, 10);
    drain();

    // Random stream with bubbles, random backpressure and occasional unsorted halves.
    idx = 0;
    cyc = 0;
    holding = 1'b0;
    d = rand_sorted();
    while (idx < 40 && cyc < 2000) begin
      ordy = ($urandom_range(0, 2) != 0);
      if (!holding && $urandom_range(0, 3) == 0) begin
        drive_cycle(1'b0, '0, ordy, dummy, acc);
      end else begin
        drive_cycle(1'b1, d, ordy, model(d), acc);
        holding = !acc;
        if (acc) begin
          idx++;
          d = ($urandom_range(0, 4) == 0) ? rand_raw() : rand_sorted();
        end
      end
      cyc++;
    end
    check("rand_all_sent", idx, 40);
    drain();

    // Reset mid-stream with three vectors in flight and the head stalled.
    for (int t = 0; t < 3; t++) begin
      d = rand_sorted();
      send(d, model(d));
    end
    drive_cycle(1'b0, '0, 1'b0, dummy, acc);
    @(negedge clk);
    #1;
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_c", c, '0);
    check("mid_rst_err", out_ord_err, 1'b0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_valid", out_valid, 1'b0);
    d = rand_sorted();
    send(d, model(d));
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n++;
      if (out_valid) got = 1'b1;
    end
    check("latency", n, S);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
